// File: rtl/hack_cpu_mc.sv
// -----------------------------------------------------------------------------
// hack_cpu_mc -- multi-cycle Hack CPU with handshaked instruction and data
// buses.
//
// This file holds the whole design:
//   hack_alu     combinational Hack ALU (x/y pre-processing, add/and,
//                optional output negation, zero/negative flags)
//   hack_cpu_mc  top level: a seven-state FSM that sequences
//                fetch, decode, optional memory read, execute,
//                optional memory write and writeback
//
// hack_cpu_mc ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   rom_addr    instruction address (always the PC)
//   rom_req     instruction fetch request, high only in FETCH
//   rom_ack     fetch complete; rom_data is valid in this cycle
//   rom_data    instruction word
//   mem_addr    data address (always A[14:0])
//   mem_rd      data read request, high only in MREAD
//   mem_wr      data write request, high only in MWRITE
//   mem_wdata   write data (the latched ALU result R)
//   mem_rdata   read data, valid while mem_ack is high during a read
//   mem_ack     data access complete
//   instr_done  one-cycle pulse in the cycle an instruction retires
//   pc_out      debug view of PC
//   a_out       debug view of A
//   d_out       debug view of D
// -----------------------------------------------------------------------------

module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x_zero;
    logic [15:0] x_pre;
    logic [15:0] y_zero;
    logic [15:0] y_pre;
    logic [15:0] f_out;

    always_comb begin
        x_zero = zx ? 16'h0000 : x;
        x_pre  = nx ? ~x_zero  : x_zero;
        y_zero = zy ? 16'h0000 : y;
        y_pre  = ny ? ~y_zero  : y_zero;
        f_out  = f  ? (x_pre + y_pre) : (x_pre & y_pre);
        out    = no ? ~f_out : f_out;
        zr     = (out == 16'h0000);
        ng     = out[15];
    end
endmodule

module hack_cpu_mc (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        instr_done,
    output logic [14:0] pc_out,
    output logic [15:0] a_out,
    output logic [15:0] d_out
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MREAD  = 3'd3,
        S_EXEC   = 3'd4,
        S_MWRITE = 3'd5,
        S_WB     = 3'd6
    } state_t;

    state_t      state_reg;
    logic [14:0] pc_reg;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] ir_reg;
    logic [15:0] mreg_reg;
    logic [15:0] r_reg;
    logic        j_reg;

    // Instruction fields of a C-instruction. IR[14:13] are don't-care.
    logic        is_c_instr;
    logic        sel_m;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic [2:0]  jmp_bits;

    assign is_c_instr = ir_reg[15];
    assign sel_m      = ir_reg[12];
    assign dest_a     = ir_reg[5];
    assign dest_d     = ir_reg[4];
    assign dest_m     = ir_reg[3];
    assign jmp_bits   = ir_reg[2:0];

    // ALU: x is always D, y selects between the memory operand and A.
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    assign alu_y = sel_m ? mreg_reg : a_reg;

    hack_alu u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (ir_reg[11]),
        .nx  (ir_reg[10]),
        .zy  (ir_reg[9]),
        .ny  (ir_reg[8]),
        .f   (ir_reg[7]),
        .no  (ir_reg[6]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    logic jump_now;
    assign jump_now = (jmp_bits[2] & alu_ng)
                    | (jmp_bits[1] & alu_zr)
                    | (jmp_bits[0] & ~alu_ng & ~alu_zr);

    // 15-bit increment: 0x7FFF + 1 wraps naturally to 0x0000.
    logic [14:0] pc_inc;
    assign pc_inc = pc_reg + 15'd1;

    // -------------------------------------------------------------------------
    // Sequencer. All architectural state lives in this one block so the
    // asynchronous reset clears everything together; a reset in the middle
    // of an access simply abandons it with no partial register update.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= 15'd0;
            a_reg     <= 16'd0;
            d_reg     <= 16'd0;
            ir_reg    <= 16'd0;
            mreg_reg  <= 16'd0;
            r_reg     <= 16'd0;
            j_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_FETCH;
                end

                S_FETCH: begin
                    if (rom_ack) begin
                        ir_reg    <= rom_data;
                        state_reg <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (!is_c_instr) begin
                        // A-instruction retires here.
                        a_reg     <= ir_reg;
                        pc_reg    <= pc_inc;
                        state_reg <= S_FETCH;
                    end else if (sel_m) begin
                        state_reg <= S_MREAD;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end

                S_MREAD: begin
                    if (mem_ack) begin
                        mreg_reg  <= mem_rdata;
                        state_reg <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    r_reg     <= alu_out;
                    j_reg     <= jump_now;
                    state_reg <= dest_m ? S_MWRITE : S_WB;
                end

                S_MWRITE: begin
                    // A is untouched until WB, so mem_addr holds the old A
                    // for the whole write even when A is also a destination.
                    if (mem_ack) begin
                        state_reg <= S_WB;
                    end
                end

                S_WB: begin
                    if (dest_a) begin
                        a_reg <= r_reg;
                    end
                    if (dest_d) begin
                        d_reg <= r_reg;
                    end
                    // Jump target is the A value from before this writeback.
                    pc_reg    <= j_reg ? a_reg[14:0] : pc_inc;
                    state_reg <= S_FETCH;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus outputs are decoded straight from the state register. Requests are
    // therefore high from the first cycle of their state (so a zero-wait ack
    // is seen immediately), drop as soon as reset forces IDLE, and an ack
    // outside the matching state has no effect.
    // -------------------------------------------------------------------------
    assign rom_req    = (state_reg == S_FETCH);
    assign mem_rd     = (state_reg == S_MREAD);
    assign mem_wr     = (state_reg == S_MWRITE);
    assign rom_addr   = pc_reg;
    assign mem_addr   = a_reg[14:0];
    assign mem_wdata  = r_reg;
    assign instr_done = ((state_reg == S_DECODE) && !is_c_instr)
                      || (state_reg == S_WB);

    assign pc_out = pc_reg;
    assign a_out  = a_reg;
    assign d_out  = d_reg;
endmodule

// File: tb/tb_hack_cpu_mc.sv
// -----------------------------------------------------------------------------
// tb_hack_cpu_mc -- bench for hack_cpu_mc.
// Programs are tables of {rom address, instruction, expected A, D, PC after
// retirement, expected cycles since the previous retirement}. Expected entries
// go to a scoreboard queue when the program is loaded and are popped as
// instr_done pulses. Behavioural ROM / RAM responders provide configurable
// ack delays and optional stray acks while no request is pending.
// -----------------------------------------------------------------------------
module tb_hack_cpu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        instr_done;
    logic [14:0] pc_out;
    logic [15:0] a_out;
    logic [15:0] d_out;

    hack_cpu_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .instr_done (instr_done),
        .pc_out     (pc_out),
        .a_out      (a_out),
        .d_out      (d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] d;
        logic [14:0] pc;
        int          lat;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    logic [15:0] rom  [0:32767];
    logic [15:0] dmem [0:32767];

    int rom_delay = 0;
    int rd_delay  = 0;
    int wr_delay  = 0;
    bit spurious  = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Bus activity observed during the last run_vectors call.
    int          wr_cycles;
    int          rd_cycles;
    logic [14:0] wr_addr_seen;
    logic [15:0] wr_data_seen;
    logic [14:0] rd_addr_seen;
    bit          wr_unstable;
    bit          req_overlap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [14:0] addr, input logic [15:0] instr,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [14:0] pc, input int lat);
        vt.push_back('{addr, instr, a, d, pc, lat});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            rom[i]  = 16'h0000;
            dmem[i] = 16'h0000;
        end
    endtask

    // Responders: evaluated away from the active edge, acks become visible
    // to the DUT at the following rising edge.
    initial begin
        int rc;
        int mc;
        int dly;
        rc = 0;
        mc = 0;
        rom_ack   = 1'b0;
        mem_ack   = 1'b0;
        rom_data  = 16'hFFFF;
        mem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (rom_req) begin
                if (rc >= rom_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = rom[rom_addr];
                    rc = 0;
                end else begin
                    rom_ack  = 1'b0;
                    rom_data = 16'hFFFF;
                    rc++;
                end
            end else begin
                rc = 0;
                rom_ack  = spurious;
                rom_data = 16'hFFFF;
            end
            if (mem_rd || mem_wr) begin
                dly = mem_rd ? rd_delay : wr_delay;
                if (mc >= dly) begin
                    mem_ack = 1'b1;
                    if (mem_rd) mem_rdata = dmem[mem_addr];
                    else        dmem[mem_addr] = mem_wdata;
                    mc = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'hDEAD;
                    mc++;
                end
            end else begin
                mc = 0;
                mem_ack   = spurious;
                mem_rdata = 16'hDEAD;
            end
        end
    end

    // Holds reset, checks the reset outputs, releases it on a falling edge
    // and checks that the first fetch appears one cycle later at address 0.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc",         pc_out,     0);
        check("rst_a",          a_out,      0);
        check("rst_d",          d_out,      0);
        check("rst_rom_req",    rom_req,    0);
        check("rst_mem_rd",     mem_rd,     0);
        check("rst_mem_wr",     mem_wr,     0);
        check("rst_instr_done", instr_done, 0);
        check("rst_mem_wdata",  mem_wdata,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch_req",  rom_req,  1);
        check("first_fetch_addr", rom_addr, 0);
    endtask

    task automatic run_vectors(input string tag, input int budget);
        int   cycle;
        int   last;
        bit   pending;
        bit   prev_wr;
        vec_t e;
        vec_t pe;
        sb.delete();
        foreach (vt[i]) begin
            rom[vt[i].addr] = vt[i].instr;
            sb.push_back(vt[i]);
        end
        wr_cycles = 0;
        rd_cycles = 0;
        wr_unstable = 1'b0;
        req_overlap = 1'b0;
        wr_addr_seen = '0;
        wr_data_seen = '0;
        rd_addr_seen = '0;
        prev_wr = 1'b0;
        pending = 1'b0;
        apply_reset();
        cycle = 1;
        last  = 0;
        while ((sb.size() > 0 || pending) && cycle < budget) begin
            @(negedge clk);
            cycle++;
            if (pending) begin
                check({tag, "_a"},  a_out,  pe.a);
                check({tag, "_d"},  d_out,  pe.d);
                check({tag, "_pc"}, pc_out, pe.pc);
                pending = 1'b0;
            end
            if ($countones({rom_req, mem_rd, mem_wr}) > 1) req_overlap = 1'b1;
            if (mem_wr) begin
                if (!prev_wr) begin
                    wr_addr_seen = mem_addr;
                    wr_data_seen = mem_wdata;
                end else if (mem_addr !== wr_addr_seen || mem_wdata !== wr_data_seen) begin
                    wr_unstable = 1'b1;
                end
                wr_cycles++;
            end
            prev_wr = mem_wr;
            if (mem_rd) begin
                rd_addr_seen = mem_addr;
                rd_cycles++;
            end
            if (instr_done && sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn %s addr=%04h instr=%04h cycles=%0d", tag, e.addr, e.instr, cycle - last);
                check({tag, "_latency"}, cycle - last, e.lat);
                last = cycle;
                pe = e;
                pending = 1'b1;
            end
        end
        check({tag, "_timeout_left"}, sb.size() + int'(pending), 0);
        check({tag, "_req_overlap"}, req_overlap, 0);
    endtask

    initial begin
        clear_mem();

        // Zero-wait program: loads, D=A, D=-1, M=D, D=M, jump, no-jump,
        // AM=D+1 (write at old A), ignored IR[14:13].
        vt.delete();
        add(15'h0000, 16'h0005, 16'h0005, 16'h0000, 15'h0001, 2);
        add(15'h0001, 16'hEC10, 16'h0005, 16'h0005, 15'h0002, 4);
        add(15'h0002, 16'hEE90, 16'h0005, 16'hFFFF, 15'h0003, 4);
        add(15'h0003, 16'h0064, 16'h0064, 16'hFFFF, 15'h0004, 2);
        add(15'h0004, 16'hE308, 16'h0064, 16'hFFFF, 15'h0005, 5);
        add(15'h0005, 16'h0003, 16'h0003, 16'hFFFF, 15'h0006, 2);
        add(15'h0006, 16'hFC10, 16'h0003, 16'h00AB, 15'h0007, 5);
        add(15'h0007, 16'h000C, 16'h000C, 16'h00AB, 15'h0008, 2);
        add(15'h0008, 16'hEA87, 16'h000C, 16'h00AB, 15'h000C, 4);
        add(15'h000C, 16'hEA90, 16'h000C, 16'h0000, 15'h000D, 4);
        add(15'h000D, 16'hE301, 16'h000C, 16'h0000, 15'h000E, 4);
        add(15'h000E, 16'h0014, 16'h0014, 16'h0000, 15'h000F, 2);
        add(15'h000F, 16'hE7E8, 16'h0001, 16'h0000, 15'h0010, 5);
        add(15'h0010, 16'h0014, 16'h0014, 16'h0000, 15'h0011, 2);
        add(15'h0011, 16'hFC10, 16'h0014, 16'h0001, 15'h0012, 5);
        add(15'h0012, 16'h8C10, 16'h0014, 16'h0014, 15'h0013, 4);
        dmem[3] = 16'h00AB;
        rom_delay = 0; rd_delay = 0; wr_delay = 0; spurious = 1'b0;
        run_vectors("zw", 400);
        check("zw_dmem_64", dmem[15'h0064], 16'hFFFF);
        check("zw_dmem_20", dmem[15'h0014], 16'h0001);
        check("zw_dmem_1",  dmem[15'h0001], 16'h0000);

        // Waited accesses with stray acks between requests.
        clear_mem();
        vt.delete();
        add(15'h0000, 16'hEE90, 16'h0000, 16'hFFFF, 15'h0001, 5);
        add(15'h0001, 16'h0064, 16'h0064, 16'hFFFF, 15'h0002, 3);
        add(15'h0002, 16'hE308, 16'h0064, 16'hFFFF, 15'h0003, 9);
        add(15'h0003, 16'h0003, 16'h0003, 16'hFFFF, 15'h0004, 3);
        add(15'h0004, 16'hFC10, 16'h0003, 16'h00AB, 15'h0005, 8);
        dmem[3] = 16'h00AB;
        rom_delay = 1; rd_delay = 2; wr_delay = 3; spurious = 1'b1;
        run_vectors("wt", 400);
        check("wt_wr_cycles",   wr_cycles,    4);
        check("wt_wr_addr",     wr_addr_seen, 15'h0064);
        check("wt_wr_data",     wr_data_seen, 16'hFFFF);
        check("wt_wr_unstable", wr_unstable,  0);
        check("wt_rd_cycles",   rd_cycles,    3);
        check("wt_rd_addr",     rd_addr_seen, 15'h0003);
        check("wt_dmem_64",     dmem[15'h0064], 16'hFFFF);

        // PC wrap at the top of ROM.
        clear_mem();
        vt.delete();
        add(15'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 15'h0001, 2);
        add(15'h0001, 16'hEA87, 16'h7FFF, 16'h0000, 15'h7FFF, 4);
        add(15'h7FFF, 16'h0005, 16'h0005, 16'h0000, 15'h0000, 2);
        rom_delay = 0; rd_delay = 0; wr_delay = 0; spurious = 1'b0;
        run_vectors("wrap", 200);

        // Reset asserted in the middle of a long write.
        clear_mem();
        rom[0] = 16'hEE90;
        rom[1] = 16'h0064;
        rom[2] = 16'hE308;
        rom_delay = 0; wr_delay = 50; spurious = 1'b0;
        apply_reset();
        for (int i = 0; i < 40 && !mem_wr; i++) @(negedge clk);
        check("mwr_seen",       mem_wr,    1);
        check("mwr_d_before",   d_out,     16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        check("mwr_async_drop", mem_wr,    0);
        check("mwr_rst_pc",     pc_out,    0);
        check("mwr_rst_a",      a_out,     0);
        check("mwr_rst_d",      d_out,     0);
        check("mwr_rst_wdata",  mem_wdata, 0);
        apply_reset();
        check("mwr_no_write",   dmem[15'h0064], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule
